fp_norm_round_pack_ctrl: RTL and testbench
==========================================

Name: fp_norm_round_pack_ctrl

Overview:
Sequencing controller in front of the single-precision packer stage. Accepts one unpacked float result (sign, 10-bit signed exponent, 24-bit mantissa plus guard/round/sticky bits) over a valid/ready handshake. Normalizes it iteratively, one shift per cycle, handling both left shifts and right shifts into the denormal range. Then rounds, packs to IEEE-754 binary32 and holds the result until it is consumed. The block sits between the add/mul datapath cores and the result bus.

Parameters:
ROUND_EN, 1, 1 = round-to-nearest-even on the G/R/S bits; 0 = truncate (G/R/S ignored)
FLUSH_LIMIT, -152, signed exponent below which a right-normalize collapses the mantissa to sticky in one cycle

Ports:
clk  in  1  clock, all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input operand valid
in_ready  out  1  block can accept an operand
in_s  in  1  sign
in_e  in  10  exponent, two's complement, unbiased
in_m  in  27  [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky
out_valid  out  1  z is valid
out_ready  in  1  consumer accepts z
z  out  32  packed binary32 result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0 while reset is asserted, 1 on the first cycle after release. out_valid=0, z=0, busy=0, internal s/e/m=0. Reset asserted in any state aborts the operation with no output.
- States: IDLE, NORM, ROUND, PACK, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch s, e and m.
  - If in_m==0: set e=-126 and go to ROUND (zero shortcut). Otherwise go to NORM.
- NORM, one action per cycle, evaluated in this priority:
  a) e < FLUSH_LIMIT: m = {26'b0, |m}; e = -126.
  b) e < -126: m = {1'b0, m[26:2], m[1]|m[0]}; e = e+1 (sticky preserved).
  c) m[26]==0 and e > -126: m = m<<1; e = e-1.
  d) Otherwise go to ROUND.
- ROUND:
  - lsb=m[3], g=m[2], r=m[1], st=m[0]; up = ROUND_EN & g & (r|st|lsb).
  - sum[24:0] = {1'b0, m[26:3]} + up.
  - If sum[24]: mant = sum[24:1], e = e+1. Else mant = sum[23:0]. Go to PACK.
  - A denormal that rounds up to 24'h800000 keeps e=-126 and then packs as exponent field 1.
- PACK, one cycle, result registered into z:
  - e > 127 (signed): z = {s, 8'hFF, 23'b0} (infinity).
  - e == -126 and mant[23]==0: z = {s, 8'h00, mant[22:0]} (denormal or zero).
  - Otherwise: z = {s, e[7:0]+8'd127, mant[22:0]}.
  - Go to HOLD.
- HOLD:
  - out_valid=1; z stable.
  - On out_ready: out_valid drops the next cycle, return to IDLE.
  - in_ready is 0 here, so no overlap of accept and deliver.
- Latency: accept edge to out_valid = N_norm + 2 cycles (N_norm ≥ 1 for nonzero inputs, including the exit cycle; 0 for the zero shortcut).
- Width rules: e arithmetic is 10-bit signed with no wrap checks beyond the rules above. Inputs must satisfy -512 ≤ in_e ≤ 511. in_e > 127 with no left shift ends as infinity.
- in_valid outside IDLE is ignored; the operand must be held by the sender until in_ready.

Test Plan:
- Normalized 1.0: in_s=0, in_e=0, in_m=27'h4000000 → z=32'h3F800000; out_valid 3 cycles after accept.
- Left normalize: in_e=3, in_m=27'h0800000 → 3 shift cycles, z=32'h3F800000; busy high throughout.
- Round-to-even carry: in_e=0, in_m=27'h7FFFFFC → mantissa overflow, z=32'h40000000. With ROUND_EN=0 → z=32'h3FFFFFFF.
- Overflow and sign: in_e=128, in_m=27'h4000000, in_s=1 → z=32'hFF800000. Signed zero: in_s=1, in_m=0 → z=32'h80000000.
- Denormal: in_e=-127 (10'h381), in_m=27'h4000000 → one right shift, z=32'h00400000. Flush: in_e=-200 → z=32'h00000000.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles → z and out_valid stable, in_ready=0.
  - Assert rst_n=0 mid-NORM → out_valid=0, z=0 immediately; in_ready=1 one cycle after release.

Source files
------------

// File: rtl/fp_norm_round_pack_ctrl.sv
// Normalize / round / pack sequencer for a single unpacked float result.
// One normalize shift per cycle, then round, pack to binary32 and hold until consumed.
module fp_norm_round_pack_ctrl #(
  parameter bit ROUND_EN    = 1'b1,
  parameter int FLUSH_LIMIT = -152
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_s,
  input  logic [9:0]  in_e,
  input  logic [26:0] in_m,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    ROUND,
    PACK,
    HOLD
  } state_t;

  localparam logic signed [9:0] E_MIN   = -10'sd126;
  localparam logic signed [9:0] E_MAX   = 10'sd127;
  localparam logic signed [9:0] E_FLUSH = 10'(FLUSH_LIMIT);

  state_t             state, state_n;
  logic               armed;
  logic               s, s_n;
  logic signed [9:0]  e, e_n;
  logic [26:0]        m, m_n;
  logic [23:0]        mant, mant_n;
  logic [31:0]        z_n;
  logic               round_up;
  logic [24:0]        sum;

  // armed keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
      s     <= 1'b0;
      e     <= '0;
      m     <= '0;
      mant  <= '0;
      z     <= '0;
    end else begin
      state <= state_n;
      armed <= 1'b1;
      s     <= s_n;
      e     <= e_n;
      m     <= m_n;
      mant  <= mant_n;
      z     <= z_n;
    end
  end

  assign in_ready  = (state == IDLE) && armed;
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  // Round-to-nearest-even on the guard bit, ties broken by the LSB
  assign round_up = ROUND_EN & m[2] & (m[1] | m[0] | m[3]);
  assign sum      = {1'b0, m[26:3]} + {24'd0, round_up};

  always_comb begin
    state_n = state;
    s_n     = s;
    e_n     = e;
    m_n     = m;
    mant_n  = mant;
    z_n     = z;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          s_n = in_s;
          e_n = in_e;
          m_n = in_m;
          if (in_m == 27'd0) begin
            e_n     = E_MIN;
            state_n = ROUND;
          end else begin
            state_n = NORM;
          end
        end
      end

      NORM: begin
        if (e < E_FLUSH) begin
          m_n = {26'd0, |m};
          e_n = E_MIN;
        end else if (e < E_MIN) begin
          m_n = {1'b0, m[26:2], m[1] | m[0]};
          e_n = e + 10'sd1;
        end else if (!m[26] && (e > E_MIN)) begin
          m_n = {m[25:0], 1'b0};
          e_n = e - 10'sd1;
        end else begin
          state_n = ROUND;
        end
      end

      ROUND: begin
        if (sum[24]) begin
          mant_n = sum[24:1];
          e_n    = e + 10'sd1;
        end else begin
          mant_n = sum[23:0];
        end
        state_n = PACK;
      end

      // A denormal rounded up to 1.0 falls through to the biased path as exponent field 1
      PACK: begin
        if (e > E_MAX) begin
          z_n = {s, 8'hFF, 23'd0};
        end else if ((e == E_MIN) && !mant[23]) begin
          z_n = {s, 8'h00, mant[22:0]};
        end else begin
          z_n = {s, e[7:0] + 8'd127, mant[22:0]};
        end
        state_n = HOLD;
      end

      HOLD: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_norm_round_pack_ctrl.sv
// Directed bench for fp_norm_round_pack_ctrl: hand-computed binary32 results,
// latency, handshake hold and mid-operation reset; a second instance truncates.
module tb_fp_norm_round_pack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_s = 1'b0;
  logic [9:0]  in_e = '0;
  logic [26:0] in_m = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, busy;
  logic [31:0] z;
  logic        in_ready_t, out_valid_t, busy_t;
  logic [31:0] z_t;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  fp_norm_round_pack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_e(in_e), .in_m(in_m), .out_valid(out_valid),
    .out_ready(out_ready), .z(z), .busy(busy)
  );

  fp_norm_round_pack_ctrl #(.ROUND_EN(1'b0)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_s(in_s), .in_e(in_e), .in_m(in_m), .out_valid(out_valid_t),
    .out_ready(out_ready), .z(z_t), .busy(busy_t)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, presents the operand for one accept edge, returns on the following negedge
  task automatic applyStimulus(input logic s, input logic [9:0] e, input logic [26:0] m);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("acceptTimeout", {31'd0, in_ready}, 32'd1);
    in_s = s;
    in_e = e;
    in_m = m;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [31:0] expZ, input int expLat);
    int lat = 0;
    logic busyHigh = 1'b1;
    while (!out_valid && lat < 60) begin
      busyHigh &= busy;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_z"}, z, expZ);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_busy"}, {31'd0, busyHigh}, 32'd1);
    checkOutput({tag, "_inReadyHold"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_validDrop"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_idleBusy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic stableOk;

    #1;
    checkOutput("rstInReady", {31'd0, in_ready}, 32'd0);
    checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstZ", z, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("relInReady0", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("relInReady1", {31'd0, in_ready}, 32'd1);

    applyStimulus(1'b0, 10'd0, 27'h4000000);
    waitResult("one", 32'h3F800000, 3);
    releaseResult("one");

    applyStimulus(1'b0, 10'd3, 27'h0800000);
    waitResult("leftNorm", 32'h3F800000, 6);
    releaseResult("leftNorm");

    applyStimulus(1'b0, 10'd0, 27'h7FFFFFC);
    waitResult("rneCarry", 32'h40000000, 3);
    checkOutput("truncZ", z_t, 32'h3FFFFFFF);
    releaseResult("rneCarry");

    applyStimulus(1'b1, 10'd0, 27'h0);
    waitResult("negZero", 32'h80000000, 2);
    releaseResult("negZero");

    applyStimulus(1'b0, 10'h381, 27'h4000000);
    waitResult("denorm", 32'h00400000, 4);
    releaseResult("denorm");

    applyStimulus(1'b0, 10'h338, 27'h4000000);
    waitResult("flush", 32'h00000000, 4);
    releaseResult("flush");

    applyStimulus(1'b1, 10'd128, 27'h4000000);
    waitResult("negInf", 32'hFF800000, 3);
    stableOk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stableOk &= (z === 32'hFF800000) && out_valid && !in_ready;
    end
    checkOutput("holdStable", {31'd0, stableOk}, 32'd1);
    releaseResult("negInf");

    applyStimulus(1'b0, 10'd3, 27'h0800000);
    checkOutput("midNormBusy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abortZ", z, 32'd0);
    checkOutput("abortOutValid", {31'd0, out_valid}, 32'd0);
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortInReady", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("abortRelInReady0", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("abortRelInReady1", {31'd0, in_ready}, 32'd1);
    checkOutput("abortRelTruncReady", {31'd0, in_ready_t}, 32'd1);

    applyStimulus(1'b1, 10'd0, 27'h4000000);
    waitResult("negOne", 32'hBF800000, 3);
    checkOutput("negOneTruncValid", {31'd0, out_valid_t}, 32'd1);
    releaseResult("negOne");
    checkOutput("negOneTruncBusy", {31'd0, busy_t}, 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
